ad_ip_jesd204_tpl_dac_start_ctrl: RTL

Transmit start/stop sequencer for the JESD204 TPL DAC datapath, in the link clock domain between the regmap control bits and the TPL DAC core.
- Arms on a request and optionally waits for an external trigger.
- Starts the datapath on a local multiframe (LMFC) boundary, issuing a one-cycle dac_sync pulse so DDS phase and DMA data start aligned.
- Stops the datapath on software disarm, link loss or sustained DMA underflow.

---
 rtl/ad_ip_jesd204_tpl_dac_start_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_start_ctrl.sv
// Start/stop sequencer for the JESD204 TPL DAC datapath (link clock domain).
// Define AD_TPL_DAC_UNF_CNT_EN to build the 16-bit total underflow counter on unf_count.
module ad_ip_jesd204_tpl_dac_start_ctrl #(
    parameter int unsigned LMFC_CNT_WIDTH  = 8,
    parameter int unsigned UNF_LIMIT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       arm,
    input  logic                       disarm,
    input  logic                       ext_sync_mode,
    input  logic                       ext_sync,
    input  logic [LMFC_CNT_WIDTH-1:0]  lmfc_period,
    input  logic                       link_ready,
    input  logic                       dac_dunf,
    input  logic [UNF_LIMIT_WIDTH-1:0] unf_limit,
    output logic                       dac_sync,
    output logic                       dp_enable,
    output logic                       armed,
    output logic [1:0]                 ctrl_state,
    output logic                       unf_stop,
    output logic                       link_lost,
    output logic [15:0]                unf_count
);

    typedef enum logic [1:0] {
        StIdle         = 2'd0,
        StArmed        = 2'd1,
        StWaitBoundary = 2'd2,
        StRun          = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [LMFC_CNT_WIDTH-1:0]  lmfc_cnt_q, lmfc_cnt_d;
    logic [UNF_LIMIT_WIDTH-1:0] unf_cnt_q, unf_cnt_d, unf_cnt_inc;
    logic                       ext_sync_q;
    logic                       dac_sync_q, dac_sync_d;
    logic                       dp_enable_q, dp_enable_d;
    logic                       armed_q, armed_d;
    logic                       unf_stop_q, unf_stop_d;
    logic                       link_lost_q, link_lost_d;
    logic                       boundary, rise, accept_arm, unf_hit;

    always_comb begin
        boundary    = (lmfc_cnt_q == lmfc_period);
        rise        = ext_sync & ~ext_sync_q;
        // A shrunk period below the current count also wraps here, without a boundary.
        lmfc_cnt_d  = (lmfc_cnt_q >= lmfc_period) ? '0 : lmfc_cnt_q + LMFC_CNT_WIDTH'(1);
        unf_cnt_inc = (&unf_cnt_q) ? unf_cnt_q : unf_cnt_q + UNF_LIMIT_WIDTH'(1);
        unf_hit     = dac_dunf && (unf_limit != '0) && (unf_cnt_inc >= unf_limit);
        accept_arm  = (state_q == StIdle) && arm && !disarm;

        state_d     = state_q;
        unf_cnt_d   = unf_cnt_q;
        unf_stop_d  = unf_stop_q;
        link_lost_d = link_lost_q;

        unique case (state_q)
            StIdle: begin
                if (accept_arm) begin
                    state_d     = ext_sync_mode ? StArmed : StWaitBoundary;
                    unf_stop_d  = 1'b0;
                    link_lost_d = 1'b0;
                    unf_cnt_d   = '0;
                end
            end
            StArmed: begin
                if (disarm) begin
                    state_d = StIdle;
                end else if (rise) begin
                    state_d = StWaitBoundary;
                end
            end
            StWaitBoundary: begin
                if (disarm) begin
                    state_d = StIdle;
                end else if (boundary && link_ready) begin
                    state_d   = StRun;
                    unf_cnt_d = '0;
                end
            end
            StRun: begin
                unf_cnt_d = dac_dunf ? unf_cnt_inc : '0;
                if (disarm) begin
                    state_d = StIdle;
                end else if (!link_ready) begin
                    state_d     = StIdle;
                    link_lost_d = 1'b1;
                end else if (unf_hit) begin
                    state_d    = StIdle;
                    unf_stop_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        dac_sync_d  = (state_q == StWaitBoundary) && (state_d == StRun);
        dp_enable_d = (state_d == StRun);
        armed_d     = (state_d == StArmed) || (state_d == StWaitBoundary);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            lmfc_cnt_q  <= '0;
            unf_cnt_q   <= '0;
            ext_sync_q  <= 1'b0;
            dac_sync_q  <= 1'b0;
            dp_enable_q <= 1'b0;
            armed_q     <= 1'b0;
            unf_stop_q  <= 1'b0;
            link_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lmfc_cnt_q  <= lmfc_cnt_d;
            unf_cnt_q   <= unf_cnt_d;
            ext_sync_q  <= ext_sync;
            dac_sync_q  <= dac_sync_d;
            dp_enable_q <= dp_enable_d;
            armed_q     <= armed_d;
            unf_stop_q  <= unf_stop_d;
            link_lost_q <= link_lost_d;
        end
    end

`ifdef AD_TPL_DAC_UNF_CNT_EN
    logic [15:0] unf_total_q, unf_total_d;

    always_comb begin
        unf_total_d = unf_total_q;
        if (accept_arm) begin
            unf_total_d = '0;
        end else if ((state_q == StRun) && dac_dunf && !(&unf_total_q)) begin
            unf_total_d = unf_total_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            unf_total_q <= '0;
        end else begin
            unf_total_q <= unf_total_d;
        end
    end

    assign unf_count = unf_total_q;
`else
    assign unf_count = 16'd0;
`endif

    assign dac_sync   = dac_sync_q;
    assign dp_enable  = dp_enable_q;
    assign armed      = armed_q;
    assign ctrl_state = state_q;
    assign unf_stop   = unf_stop_q;
    assign link_lost  = link_lost_q;

endmodule
